ext_unit_pipe: RTL and testbench
================================

EXT_UNIT_PIPE -- requirements
Module: ext_unit_pipe

Interface
REQ-001 Parameter: IN_W, default 16, immediate input width in bits.
REQ-002 Parameter: OUT_W, default 32, extended output width in bits; legal only when OUT_W >= IN_W+2.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  synchronous active-low reset, sampled on the rising edge of Clk.
REQ-005 In_valid  input  1  upstream presents a word.
REQ-006 In_ready  output  1  block accepts a word this cycle.
REQ-007 In_data  input  IN_W  immediate field.
REQ-008 Mode  input  2  extension mode, sampled together with In_data.
REQ-009 Out_valid  output  1  Out_data holds a result.
REQ-010 Out_ready  input  1  downstream consumes the result this cycle.
REQ-011 Out_data  output  OUT_W  extended result.
REQ-012 Out_mode  output  2  Mode value captured with the word, travelling with Out_data.

Function
REQ-013 Transfer in: In_valid && In_ready at a rising edge; transfer out: Out_valid && Out_ready at a rising edge.
REQ-014 Mode 0 (zero-extend): Out_data = {(OUT_W-IN_W) zeros, In_data}.
REQ-015 Mode 1 (sign-extend): Out_data = {(OUT_W-IN_W) copies of In_data[IN_W-1], In_data}.
REQ-016 Mode 2 (upper-load): Out_data = In_data << (OUT_W-IN_W), low bits zero.
REQ-017 Mode 3 (branch offset): Out_data = (sign-extended value << 2), truncated to OUT_W bits.
REQ-018 Latency: a word accepted at edge N has Out_valid=1 and its result on Out_data after edge N.
REQ-019 While Out_valid=1 and Out_ready=0, Out_data and Out_mode hold stable.
REQ-020 Words leave in acceptance order; none dropped or duplicated.
REQ-021 Simultaneous transfer in and out in the same cycle: the output register reloads with the next word; Out_valid stays 1.
REQ-022 In_ready=0 whenever Rst_n=0.

Reset
REQ-023 On a rising edge with Rst_n=0: Out_valid=0, Out_data=0, Out_mode=0, and all buffered words discarded.
REQ-024 Reset asserted mid-operation discards pending words; no stale word is presented after reset release.
REQ-025 The first cycle after reset release: In_ready=1 and Out_valid=0.

Configuration
REQ-026 Macro EXT_UNIT_SKID_EN selects the input buffering scheme.
REQ-027 Without EXT_UNIT_SKID_EN: a single output register is used; In_ready = Rst_n && (!Out_valid || Out_ready), combinationally dependent on Out_ready.
REQ-028 With EXT_UNIT_SKID_EN: In_ready is driven from a flop, and a skid register backs the output register.
REQ-029 The skid buffer has three states: EMPTY, ONE (output register valid) and TWO (output and skid registers valid).
REQ-030 EMPTY -> ONE on a transfer in.
REQ-031 ONE -> TWO on a transfer in without a transfer out.
REQ-032 ONE -> EMPTY on a transfer out without a transfer in.
REQ-033 ONE stays ONE on a simultaneous transfer in and out.
REQ-034 TWO -> ONE on a transfer out; the skid word moves into the output register.
REQ-035 In_ready=0 in TWO.
REQ-036 With EXT_UNIT_SKID_EN, full throughput (one word per cycle) is sustained while Out_ready=1.

Verification
REQ-037 Mode=1, In_data=16'h8001, Out_ready=1 -> Out_data=32'hFFFF8001 and Out_mode=1 one cycle after acceptance.
REQ-038 Back-to-back Mode 0/2/3 with In_data 16'h8001/16'h1234/16'hFFFF -> outputs 32'h00008001, 32'h12340000, 32'hFFFFFFFC, in that order.
REQ-039 Out_ready=0 for 3 cycles with words offered -> Out_data stable. Without skid: one word accepted. With skid: two words accepted, In_ready=0 in the third cycle, and both words emerge in order after Out_ready=1.
REQ-040 Continuous In_valid=1, Out_ready=1, 8 words -> 8 results on 8 consecutive cycles, the first 1 cycle after the first acceptance.
REQ-041 Rst_n=0 for one edge while holding two words (skid build) -> next cycle Out_valid=0; after release, only newly accepted words appear.
REQ-042 IN_W=8, OUT_W=16: Mode 1, In_data=8'h80 -> 16'hFF80; Mode 2, In_data=8'h7F -> 16'h7F00.

Source files
------------

// File: rtl/ext_unit_pipe.sv
// Immediate-extension pipeline stage with valid/ready handshakes on both sides.
// Define EXT_UNIT_SKID_EN for a registered in_ready backed by a skid register.
module ext_unit_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  // Extension modes: zero, sign, upper-load, branch offset (sign-extended word offset)
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] r;
    sext = {{EXT_W{d[IN_W-1]}}, d};
    case (m)
      2'd0:    r = {{EXT_W{1'b0}}, d};
      2'd1:    r = sext;
      2'd2:    r = {d, {EXT_W{1'b0}}};
      default: r = sext << 2;
    endcase
    return r;
  endfunction

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

`ifdef EXT_UNIT_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  skid_state_e      state_q;
  skid_state_e      state_nxt;
  logic             rdy_q;
  logic [OUT_W-1:0] skid_data;
  logic [1:0]       skid_mode;

  // State register; in_ready is precomputed from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      rdy_q   <= (state_nxt != TWO);
    end
  end

  // Occupancy transitions
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: if (xfer_in) state_nxt = ONE;
      ONE: begin
        if (xfer_in && !xfer_out)      state_nxt = TWO;
        else if (!xfer_in && xfer_out) state_nxt = EMPTY;
      end
      TWO:     if (xfer_out) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs decoded from flops only (rst_n gating keeps in_ready low in reset)
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_valid = (state_q != EMPTY);
    in_ready  = rdy_q && rst_n;
  end

  // Output register fed from input or skid; skid catches the word arriving under a stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_mode  <= 2'd0;
      skid_data <= '0;
      skid_mode <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            out_data <= extend(in_data, mode);
            out_mode <= mode;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            out_data <= extend(in_data, mode);
            out_mode <= mode;
          end else if (xfer_in) begin
            skid_data <= extend(in_data, mode);
            skid_mode <= mode;
          end
        end
        TWO: begin
          if (xfer_out) begin
            out_data <= skid_data;
            out_mode <= skid_mode;
          end
        end
        default: ;
      endcase
    end
  end

`else

  // Single output register; in_ready looks through to out_ready
  assign in_ready = rst_n && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 2'd0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= extend(in_data, mode);
      out_mode  <= mode;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: directed and random traffic against a
// queue-based reference; adapts expectations when EXT_UNIT_SKID_EN is defined.
module tb_ext_unit_pipe;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
`ifdef EXT_UNIT_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [1:0]        out_mode;

  logic              v8;
  logic              r8;
  logic [7:0]        d8;
  logic [1:0]        m8;
  logic              ov8;
  logic [15:0]       od8;
  logic [1:0]        om8;

  always #5 clk = ~clk;

  ext_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode)
  );

  ext_unit_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_data(d8), .mode(m8), .out_valid(ov8), .out_ready(1'b1),
    .out_data(od8), .out_mode(om8)
  );

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [1:0]       m;
  } exp_t;

  exp_t             q[$];
  int               tests = 0;
  int               fails = 0;
  int               acc_cnt = 0;
  int               out_cnt = 0;
  bit               rst_seen = 0;
  bit               hold = 0;
  logic [OUT_W-1:0] hd;
  logic [1:0]       hm;

  // Reference extension from signed/unsigned integer arithmetic
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint u;
    longint s;
    longint r;
    u = longint'(d);
    s = (u >= 64'sd32768) ? u - 64'sd65536 : u;
    case (m)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = u * 64'sd65536;
      default: r = s * 64'sd4;
    endcase
    return OUT_W'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check at negedge, update the model, then step past the next rising edge
  task automatic cycle();
    @(negedge clk);
    if (!rst_n) begin
      check("rst_in_ready", 64'(in_ready), 64'd0);
      if (rst_seen) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
      end
    end else begin
      check("in_ready", 64'(in_ready),
            64'((CAP == 1) ? (q.size() == 0 || out_ready) : (q.size() < 2)));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (hold) begin
        check("hold_data", 64'(out_data), 64'(hd));
        check("hold_mode", 64'(out_mode), 64'(hm));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        check("out_data", 64'(out_data), 64'(q[0].d));
        check("out_mode", 64'(out_mode), 64'(q[0].m));
        void'(q.pop_front());
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{d: ref_ext(in_data, mode), m: mode});
        acc_cnt++;
      end
    end
    hold = rst_n && out_valid && !out_ready;
    hd   = out_data;
    hm   = out_mode;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rst_seen = 1'b1;
      hold     = 1'b0;
    end else begin
      rst_seen = 1'b0;
    end
    #1;
  endtask

  initial begin
    int a0;
    int o0;
    logic [IN_W-1:0] corner [5];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h8001;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'd0; out_ready = 1'b1;
    v8 = 1'b0; d8 = '0; m8 = 2'd0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Sign extension of a negative immediate
    in_valid = 1'b1; mode = 2'd1; in_data = 16'h8001;
    cycle();
    in_valid = 1'b0;
    check("sext_valid", 64'(out_valid), 64'd1);
    check("sext_data", 64'(out_data), 64'hFFFF8001);
    check("sext_mode", 64'(out_mode), 64'd1);
    cycle();

    // Back-to-back zero / upper / branch
    in_valid = 1'b1; mode = 2'd0; in_data = 16'h8001;
    cycle();
    check("b2b_zext", 64'(out_data), 64'h00008001);
    mode = 2'd2; in_data = 16'h1234;
    cycle();
    check("b2b_upper", 64'(out_data), 64'h12340000);
    mode = 2'd3; in_data = 16'hFFFF;
    cycle();
    check("b2b_branch", 64'(out_data), 64'hFFFFFFFC);
    in_valid = 1'b0;
    repeat (2) cycle();

    // Stall with words offered for three cycles
    a0 = acc_cnt;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(16'h0100 + i); mode = 2'(i);
      cycle();
    end
    check("stall_accepted", 64'(acc_cnt - a0), 64'(CAP));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("stall_drained", 64'(q.size()), 64'd0);

    // Eight words streaming at full rate
    a0 = acc_cnt; o0 = out_cnt;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'($urandom); mode = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    check("stream_accepted", 64'(acc_cnt - a0), 64'd8);
    check("stream_out_7", 64'(out_cnt - o0), 64'd7);
    cycle();
    check("stream_out_8", 64'(out_cnt - o0), 64'd8);

    // Reset while holding buffered words
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'(16'hA500 + i); mode = 2'd1;
      cycle();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    rst_n = 1'b1; out_ready = 1'b1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    cycle();
    in_valid = 1'b1; in_data = 16'h00C3; mode = 2'd0;
    cycle();
    in_valid = 1'b0;
    check("post_rst_new", 64'(out_data), 64'h000000C3);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = ($urandom_range(4) == 0) ? corner[$urandom_range(4)] : 16'($urandom);
      mode      = 2'($urandom);
      if ($urandom_range(150) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    check("final_empty", 64'(q.size()), 64'd0);
    check("final_valid", 64'(out_valid), 64'd0);

    // Narrow instance
    check("n8_ready", 64'(r8), 64'd1);
    v8 = 1'b1; m8 = 2'd1; d8 = 8'h80;
    cycle();
    check("n8_sext_valid", 64'(ov8), 64'd1);
    check("n8_sext", 64'(od8), 64'hFF80);
    check("n8_sext_mode", 64'(om8), 64'd1);
    m8 = 2'd2; d8 = 8'h7F;
    cycle();
    v8 = 1'b0;
    check("n8_upper", 64'(od8), 64'h7F00);
    check("n8_upper_mode", 64'(om8), 64'd2);
    cycle();
    check("n8_drained", 64'(ov8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
